// File: rtl/dm_access_pkg.sv
// Shared types for the data-memory access controller: owner, FSM state and request payload.
package dm_access_pkg;

    localparam int unsigned DM_ADDR_WIDTH = 32;
    localparam int unsigned DM_DATA_WIDTH = 32;

    typedef enum logic {
        DM_OWNER_PIPE = 1'b0,
        DM_OWNER_DBG  = 1'b1
    } dm_owner_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } dm_ctrl_state_t;

    typedef struct packed {
        logic                     we;
        logic [DM_ADDR_WIDTH-1:0] addr;
        logic [DM_DATA_WIDTH-1:0] wdata;
    } dm_request_t;

endpackage

// File: rtl/dm_priority_arbiter.sv
// Pipeline-first arbiter with a bounded pipeline streak so the debug port cannot starve.
module dm_priority_arbiter
    import dm_access_pkg::*;
#(
    parameter int unsigned PIPE_STREAK_MAX = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      pipe_req,
    input  logic      dbg_req,
    input  logic      grant,
    output dm_owner_t winner
);

    localparam int unsigned STREAK_WIDTH = $clog2(PIPE_STREAK_MAX + 1);

    logic [STREAK_WIDTH-1:0] streak;
    logic                    streakFull;

    assign streakFull = (streak == STREAK_WIDTH'(PIPE_STREAK_MAX));

    always_comb begin
        winner = DM_OWNER_PIPE;
        if (dbg_req && (!pipe_req || streakFull)) begin
            winner = DM_OWNER_DBG;
        end
    end

    // Streak counts pipeline wins that made a waiting debug request wait
    always_ff @(posedge clock) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if (winner == DM_OWNER_PIPE && dbg_req && !streakFull) begin
                streak <= streak + STREAK_WIDTH'(1);
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/dm_access_controller.sv
// Shares the single-port data memory between the pipeline and debug ports, one access at a time.
// Optional DM_ACCESS_ALIGN_CHECK_EN adds misaligned-address faulting (pipe_fault/dbg_fault).
module dm_access_controller
    import dm_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DM_DATA_WIDTH,
    parameter int unsigned PIPE_STREAK_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_req,
    input  logic                  pipe_we,
    input  logic [ADDR_WIDTH-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    output logic                  pipe_stall,
    output logic                  pipe_done,
    output logic [DATA_WIDTH-1:0] pipe_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_done,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
`ifdef DM_ACCESS_ALIGN_CHECK_EN
    output logic                  pipe_fault,
    output logic                  dbg_fault,
`endif
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    dm_ctrl_state_t state, stateNext;
    dm_owner_t      owner, ownerNext, winner;
    dm_request_t    reqQ, selReq;
    logic [DATA_WIDTH-1:0] rdataQ, rdataNext;
    logic           grant;
    logic           doneNext;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
    logic           misQ, misNext;
`endif

    dm_priority_arbiter #(
        .PIPE_STREAK_MAX(PIPE_STREAK_MAX)
    ) u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .pipe_req(pipe_req),
        .dbg_req (dbg_req),
        .grant   (grant),
        .winner  (winner)
    );

    always_comb begin
        selReq = '0;
        if (winner == DM_OWNER_DBG) begin
            selReq.we    = dbg_we;
            selReq.addr  = DM_ADDR_WIDTH'(dbg_addr);
            selReq.wdata = DM_DATA_WIDTH'(dbg_wdata);
        end else begin
            selReq.we    = pipe_we;
            selReq.addr  = DM_ADDR_WIDTH'(pipe_addr);
            selReq.wdata = DM_DATA_WIDTH'(pipe_wdata);
        end
    end

    // Next-state and next-output logic; rdata restarts at zero for every new grant
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        rdataNext = rdataQ;
        grant     = 1'b0;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
        misNext   = misQ;
`endif
        case (state)
            IDLE: begin
                if (pipe_req || dbg_req) begin
                    grant     = 1'b1;
                    ownerNext = winner;
                    rdataNext = '0;
                    stateNext = ISSUE;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
                    misNext = (selReq.addr[1:0] != 2'b00);
                    if (misNext) begin
                        stateNext = DONE;
                    end
`endif
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    stateNext = reqQ.we ? DONE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    rdataNext = mem_rdata;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= DM_OWNER_PIPE;
            reqQ       <= '0;
            rdataQ     <= '0;
            mem_req    <= 1'b0;
            pipe_done  <= 1'b0;
            dbg_done   <= 1'b0;
            pipe_rdata <= '0;
            dbg_rdata  <= '0;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
            misQ       <= 1'b0;
            pipe_fault <= 1'b0;
            dbg_fault  <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            rdataQ    <= rdataNext;
            mem_req   <= (stateNext == ISSUE);
            pipe_done <= doneNext && (ownerNext == DM_OWNER_PIPE);
            dbg_done  <= doneNext && (ownerNext == DM_OWNER_DBG);
            if (grant) begin
                reqQ <= selReq;
            end
            if (doneNext && ownerNext == DM_OWNER_PIPE) begin
                pipe_rdata <= rdataNext;
            end
            if (doneNext && ownerNext == DM_OWNER_DBG) begin
                dbg_rdata <= rdataNext;
            end
`ifdef DM_ACCESS_ALIGN_CHECK_EN
            misQ       <= misNext;
            pipe_fault <= doneNext && misNext && (ownerNext == DM_OWNER_PIPE);
            dbg_fault  <= doneNext && misNext && (ownerNext == DM_OWNER_DBG);
`endif
        end
    end

    // Memory side sees only the latched request, never the live inputs
    assign mem_we     = reqQ.we;
    assign mem_addr   = ADDR_WIDTH'(reqQ.addr);
    assign mem_wdata  = DATA_WIDTH'(reqQ.wdata);
    assign pipe_stall = pipe_req && !pipe_done;

endmodule

// File: tb/tb_dm_access_controller.sv
// Scoreboard bench for dm_access_controller: directed stimulus, expected completions queued and checked by a monitor.
module tb_dm_access_controller;

    logic        clock;
    logic        reset;
    logic        pipe_req, pipe_we;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        pipe_stall, pipe_done;
    logic [31:0] pipe_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_done;
    logic [31:0] dbg_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
    logic        pipe_fault, dbg_fault;
`endif

    dm_access_controller dut (
        .clock     (clock),
        .reset     (reset),
        .pipe_req  (pipe_req),
        .pipe_we   (pipe_we),
        .pipe_addr (pipe_addr),
        .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .pipe_done (pipe_done),
        .pipe_rdata(pipe_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_done  (dbg_done),
        .dbg_rdata (dbg_rdata),
`ifdef DM_ACCESS_ALIGN_CHECK_EN
        .pipe_fault(pipe_fault),
        .dbg_fault (dbg_fault),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        isDbg;
        logic [31:0] rdata;
        int          cyc;
        logic        fault;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic toCyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic pushExp(input logic isDbg, input logic [31:0] rdata, input int at, input logic fault);
        exp_t e;
        e.isDbg = isDbg;
        e.rdata = rdata;
        e.cyc   = at;
        e.fault = fault;
        expQ.push_back(e);
    endtask

    // Monitor: every completion pulse must match the oldest expected completion
    always @(negedge clock) begin
        if (pipe_done || dbg_done) begin
            if (pipe_done && dbg_done) begin
                nChecks++;
                nFails++;
                $display("FAIL done_both at cycle %0d: pipe_done and dbg_done both 1, expected one", cyc);
            end else if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_done at cycle %0d: pipe_done=%0b dbg_done=%0b, expected none", cyc, pipe_done, dbg_done);
            end else begin
                monEntry = expQ.pop_front();
                check("done_owner", 32'(dbg_done), 32'(monEntry.isDbg));
                check("done_cycle", 32'(cyc), 32'(monEntry.cyc));
                check("done_rdata", dbg_done ? dbg_rdata : pipe_rdata, monEntry.rdata);
`ifdef DM_ACCESS_ALIGN_CHECK_EN
                check("done_fault", 32'(dbg_done ? dbg_fault : pipe_fault), 32'(monEntry.fault));
`endif
            end
        end
    end

    initial begin
        int t;
        int t2;
        reset = 1'b1;
        pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pipe_done", 32'(pipe_done), 32'd0);
        check("rst_dbg_done", 32'(dbg_done), 32'd0);
        check("rst_pipe_rdata", pipe_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Pipe write, memory ready immediately
        t = cyc;
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF;
        mem_ready = 1'b1;
        pushExp(1'b0, 32'h0, t + 2, 1'b0);
        #1 check("wr_stall_T", 32'(pipe_stall), 32'd1);
        toCyc(t + 1);
        check("wr_mem_req", 32'(mem_req), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_stall_T1", 32'(pipe_stall), 32'd1);
        toCyc(t + 2);
        check("wr_mem_req_once", 32'(mem_req), 32'd0);
        check("wr_stall_T2", 32'(pipe_stall), 32'd0);
        pipe_req = 1'b0;

        // Pipe read, ready delayed, stray rvalid in ISSUE, rvalid two cycles after ready
        toCyc(t + 3);
        t = cyc;
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 32'h10; pipe_wdata = 32'h0;
        mem_ready = 1'b0;
        pushExp(1'b0, 32'hDEADBEEF, t + 7, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            toCyc(t + k);
            check("rd_hold_req", 32'(mem_req), 32'd1);
            check("rd_hold_addr", mem_addr, 32'h10);
            check("rd_hold_we", 32'(mem_we), 32'd0);
            if (k == 2) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
            end
            if (k == 3) mem_rvalid = 1'b0;
            if (k == 4) mem_ready = 1'b1;
        end
        toCyc(t + 5);
        mem_ready = 1'b0;
        check("rd_wait_no_req", 32'(mem_req), 32'd0);
        toCyc(t + 6);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        toCyc(t + 7);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        pipe_req = 1'b0;
        toCyc(t + 9);
        check("rd_rdata_hold", pipe_rdata, 32'hDEADBEEF);

        // Both ports held: four pipe grants then one debug grant, twice
        t = cyc;
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h100; pipe_wdata = 32'h1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h2;
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pushExp((k % 5) == 4, 32'h0, t + 2 + 3 * k, 1'b0);
        end
        toCyc(t + 29);
        pipe_req = 1'b0; dbg_req = 1'b0;

        // Debug read aborted by reset in WAIT_RESP; late rvalid must be ignored
        toCyc(t + 30);
        t = cyc;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wdata = 32'h0;
        mem_ready = 1'b1;
        toCyc(t + 2);
        reset = 1'b1;
        toCyc(t + 3);
        reset = 1'b0;
        dbg_req = 1'b0;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        toCyc(t + 4);
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        toCyc(t + 5);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        check("stale_mem_req", 32'(mem_req), 32'd0);
        check("stale_dbg_done", 32'(dbg_done), 32'd0);
        toCyc(t + 6);
        t2 = cyc;
        dbg_req = 1'b1; dbg_addr = 32'h24;
        pushExp(1'b1, 32'h12345678, t2 + 3, 1'b0);
        toCyc(t2 + 2);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        toCyc(t2 + 3);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        dbg_req = 1'b0;

        // Simultaneous first requests: pipe first, debug right after
        toCyc(t2 + 4);
        t = cyc;
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h40; pipe_wdata = 32'h11112222;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
        pushExp(1'b0, 32'h0, t + 2, 1'b0);
        pushExp(1'b1, 32'hCAFEF00D, t + 6, 1'b0);
        #1 check("sim_stall_T", 32'(pipe_stall), 32'd1);
        toCyc(t + 1);
        check("sim_stall_T1", 32'(pipe_stall), 32'd1);
        check("sim_pipe_addr", mem_addr, 32'h40);
        toCyc(t + 2);
        check("sim_stall_T2", 32'(pipe_stall), 32'd0);
        pipe_req = 1'b0;
        toCyc(t + 3);
        check("sim_stall_T3", 32'(pipe_stall), 32'd0);
        toCyc(t + 4);
        check("sim_dbg_req", 32'(mem_req), 32'd1);
        check("sim_dbg_addr", mem_addr, 32'h44);
        check("sim_dbg_we", 32'(mem_we), 32'd0);
        toCyc(t + 5);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        toCyc(t + 6);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        dbg_req = 1'b0;

`ifdef DM_ACCESS_ALIGN_CHECK_EN
        // Misaligned pipe read faults without touching memory
        toCyc(t + 7);
        t = cyc;
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 32'h13;
        pushExp(1'b0, 32'h0, t + 1, 1'b1);
        toCyc(t + 1);
        check("align_no_req_T1", 32'(mem_req), 32'd0);
        pipe_req = 1'b0;
        toCyc(t + 2);
        check("align_no_req_T2", 32'(mem_req), 32'd0);
`endif

        // Drain: every expected completion must have been seen
        t = cyc;
        while (expQ.size() != 0 && cyc < t + 20) @(negedge clock);
        check("pending_completions", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
